// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the stream credit arbiter.
package stream_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Credit counter must hold 0..max inclusive.
  function automatic int credit_w(input int max_in_flight);
    return clog2(max_in_flight + 1);
  endfunction

  localparam int MAX_IN_FLIGHT_DEF = 128;
  localparam int CREDIT_W_DEF      = credit_w(MAX_IN_FLIGHT_DEF);

endpackage

// File: rtl/stream_credit_arbiter_if.sv
// Stream bundle between the producers, the arbiter and the shared pipeline.
// slave: the arbiter's view (sinks the producer streams, sources m_axis).
// master: the environment's view (drives producers, sinks m_axis).
interface stream_credit_arbiter_if #(
  parameter int NUM_SOURCES  = 4,
  parameter int STREAM_WIDTH = 32,
  parameter int KEEP_WIDTH   = 1,
  parameter int ID_WIDTH     = 2
);
  logic [NUM_SOURCES-1:0]              s_axis_tvalid;
  logic [NUM_SOURCES-1:0]              s_axis_tready;
  logic [NUM_SOURCES-1:0]              s_axis_tlast;
  logic [NUM_SOURCES*STREAM_WIDTH-1:0] s_axis_tdata;
  logic [NUM_SOURCES*KEEP_WIDTH-1:0]   s_axis_tkeep;
  logic                                m_axis_tvalid;
  logic                                m_axis_tready;
  logic                                m_axis_tlast;
  logic [STREAM_WIDTH-1:0]             m_axis_tdata;
  logic [KEEP_WIDTH-1:0]               m_axis_tkeep;
  logic [ID_WIDTH-1:0]                 m_axis_tid;

  modport slave (
    input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
           m_axis_tid
  );

  modport master (
    output s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
           m_axis_tid
  );
endinterface

// File: rtl/stream_credit_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_req
);
  assign any_req = |req;

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int  j;
    logic found;
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found      = 1'b1;
        gnt_oh[j]  = 1'b1;
        gnt_idx    = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/stream_credit_arbiter.sv
// Packet-atomic round-robin arbiter in front of a fixed-latency pipeline,
// with a credit counter bounding elements in flight.
module stream_credit_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_SOURCES   = 4,
  parameter int MAX_IN_FLIGHT = 128,
  parameter int STREAM_WIDTH  = 32,
  parameter int KEEP_WIDTH    = 1,
  parameter int ID_WIDTH      = 2
) (
  input  logic                     aclk,
  input  logic                     reset,
  stream_credit_arbiter_if.slave   bus,
  input  logic                     sigRelease,
  output logic                     released,
  output logic                     underflow
);
  localparam int CW = credit_w(MAX_IN_FLIGHT);

  arb_state_e              state, state_nxt;
  logic [ID_WIDTH-1:0]     grant, grant_nxt, rr_ptr, rr_nxt;
  logic [NUM_SOURCES-1:0]  grant_oh, grant_oh_nxt;
  logic [CW-1:0]           credits, credits_nxt;
  logic                    underflow_nxt;

  logic                    m_valid, m_valid_nxt, m_last;
  logic [STREAM_WIDTH-1:0] m_data;
  logic [KEEP_WIDTH-1:0]   m_keep;
  logic [ID_WIDTH-1:0]     m_id;

  logic [NUM_SOURCES-1:0]  arb_oh;
  logic [ID_WIDTH-1:0]     arb_idx;
  logic                    arb_any;

  logic                    sel_valid, sel_last, can_accept, accept;
  logic [STREAM_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0]   sel_keep;

  rr_arbiter #(.N(NUM_SOURCES), .IDX_W(ID_WIDTH)) u_rr (
    .req     (bus.s_axis_tvalid),
    .ptr     (rr_ptr),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  // Mux the granted source's beat.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (grant_oh[i]) begin
        sel_valid = bus.s_axis_tvalid[i];
        sel_last  = bus.s_axis_tlast[i];
        sel_data  = bus.s_axis_tdata[i*STREAM_WIDTH +: STREAM_WIDTH];
        sel_keep  = bus.s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
      end
    end
  end

  // Ready only for the granted source, with credit and output-register room.
  assign can_accept = !reset && (state == STREAM) && (credits < CW'(MAX_IN_FLIGHT)) &&
                      (!m_valid || bus.m_axis_tready);
  assign accept     = can_accept && sel_valid;
  assign bus.s_axis_tready = can_accept ? grant_oh : '0;

  // Arbitration FSM: grant in IDLE, hold through the packet's tlast.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    grant_oh_nxt = grant_oh;
    rr_nxt       = rr_ptr;
    case (state)
      IDLE: if (arb_any) begin
        grant_nxt    = arb_idx;
        grant_oh_nxt = arb_oh;
        state_nxt    = STREAM;
      end
      STREAM: if (accept && sel_last) begin
        state_nxt = IDLE;
        rr_nxt    = (grant == ID_WIDTH'(NUM_SOURCES - 1)) ? '0 : grant + ID_WIDTH'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Credit, output-valid and status next-state.
  always_comb begin
    credits_nxt   = credits;
    underflow_nxt = underflow;
    case ({accept, sigRelease})
      2'b10: credits_nxt = credits + CW'(1);
      2'b01: if (credits != '0) credits_nxt = credits - CW'(1);
             else               underflow_nxt = 1'b1;
      default: credits_nxt = credits;
    endcase
    if (accept)                  m_valid_nxt = 1'b1;
    else if (bus.m_axis_tready)  m_valid_nxt = 1'b0;
    else                         m_valid_nxt = m_valid;
  end

  // State, credit and output registers.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      grant_oh  <= '0;
      rr_ptr    <= '0;
      credits   <= '0;
      underflow <= 1'b0;
      released  <= 1'b1;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
      m_keep    <= '0;
      m_id      <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      grant_oh  <= grant_oh_nxt;
      rr_ptr    <= rr_nxt;
      credits   <= credits_nxt;
      underflow <= underflow_nxt;
      released  <= (credits_nxt == '0) && !m_valid_nxt;
      m_valid   <= m_valid_nxt;
      if (accept) begin
        m_last <= sel_last;
        m_data <= sel_data;
        m_keep <= sel_keep;
        m_id   <= grant;
      end
    end
  end

  assign bus.m_axis_tvalid = m_valid;
  assign bus.m_axis_tlast  = m_last;
  assign bus.m_axis_tdata  = m_data;
  assign bus.m_axis_tkeep  = m_keep;
  assign bus.m_axis_tid    = m_id;

endmodule

// File: tb/tb_stream_credit_arbiter.sv
// Directed bench for stream_credit_arbiter (4 sources, 4 credits).
module tb_stream_credit_arbiter;
  localparam int NS = 4, MIF = 4, SW = 32, KW = 1, IW = 2;

  logic aclk, reset, sigRelease, released, underflow;
  int   n_chk, n_fail;

  stream_credit_arbiter_if #(.NUM_SOURCES(NS), .STREAM_WIDTH(SW), .KEEP_WIDTH(KW),
                             .ID_WIDTH(IW)) bus ();

  stream_credit_arbiter #(.NUM_SOURCES(NS), .MAX_IN_FLIGHT(MIF), .STREAM_WIDTH(SW),
                          .KEEP_WIDTH(KW), .ID_WIDTH(IW)) dut (
    .aclk(aclk), .reset(reset), .bus(bus), .sigRelease(sigRelease),
    .released(released), .underflow(underflow)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic src(input int i, input logic v, input logic [31:0] d, input logic l);
    bus.s_axis_tvalid[i]          = v;
    bus.s_axis_tdata[i*SW +: SW]  = d;
    bus.s_axis_tlast[i]           = l;
    bus.s_axis_tkeep[i]           = 1'b1;
  endtask

  task automatic release_n(input int n);
    sigRelease = 1'b1;
    repeat (n) tick();
    sigRelease = 1'b0;
  endtask

  // Sources 0 and 2 each send a 2-beat packet; src0 must win and finish first.
  task automatic round2(input logic [31:0] a, input logic [31:0] b);
    src(0, 1'b1, a, 1'b0);
    src(2, 1'b1, b, 1'b0);
    tick();
    chk("rr_grant_src0", bus.s_axis_tready, 4'b0001);
    tick();
    chk("rr_beat0_data", bus.m_axis_tdata, a);
    chk("rr_beat0_tid", bus.m_axis_tid, 0);
    src(0, 1'b1, a + 1, 1'b1);
    chk("rr_no_interleave", bus.s_axis_tready, 4'b0001);
    tick();
    chk("rr_beat1_data", bus.m_axis_tdata, a + 1);
    chk("rr_beat1_last", bus.m_axis_tlast, 1'b1);
    src(0, 1'b0, 0, 1'b0);
    tick();
    chk("rr_grant_src2", bus.s_axis_tready, 4'b0100);
    tick();
    chk("rr_beat2_data", bus.m_axis_tdata, b);
    chk("rr_beat2_tid", bus.m_axis_tid, 2);
    src(2, 1'b1, b + 1, 1'b1);
    tick();
    chk("rr_beat3_data", bus.m_axis_tdata, b + 1);
    chk("rr_beat3_last", bus.m_axis_tlast, 1'b1);
    src(2, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int k, acc;
    logic will;
    n_chk = 0; n_fail = 0;
    reset = 1'b1; sigRelease = 1'b0;
    bus.s_axis_tvalid = '0; bus.s_axis_tlast = '0;
    bus.s_axis_tdata  = '0; bus.s_axis_tkeep = '0;
    bus.m_axis_tready = 1'b1;
    src(1, 1'b1, 32'hA, 1'b0);
    tick(); tick();
    // Reset state
    chk("rst_tready", bus.s_axis_tready, 4'b0000);
    chk("rst_mvalid", bus.m_axis_tvalid, 1'b0);
    chk("rst_tid", bus.m_axis_tid, 0);
    chk("rst_released", released, 1'b1);
    chk("rst_underflow", underflow, 1'b0);
    chk("rst_credits", dut.credits, 0);

    // Single 3-beat packet from source 1
    reset = 1'b0;
    tick();
    chk("p1_grant", bus.s_axis_tready, 4'b0010);
    tick();
    chk("p1_a_valid", bus.m_axis_tvalid, 1'b1);
    chk("p1_a_data", bus.m_axis_tdata, 32'hA);
    chk("p1_a_tid", bus.m_axis_tid, 1);
    chk("p1_a_keep", bus.m_axis_tkeep, 1'b1);
    chk("p1_a_last", bus.m_axis_tlast, 1'b0);
    chk("p1_released0", released, 1'b0);
    src(1, 1'b1, 32'hB, 1'b0);
    tick();
    chk("p1_b_data", bus.m_axis_tdata, 32'hB);
    src(1, 1'b1, 32'hC, 1'b1);
    tick();
    chk("p1_c_data", bus.m_axis_tdata, 32'hC);
    chk("p1_c_last", bus.m_axis_tlast, 1'b1);
    chk("p1_c_tid", bus.m_axis_tid, 1);
    chk("p1_credits", dut.credits, 3);
    src(1, 1'b0, 0, 1'b0);
    tick();
    chk("p1_drain_valid", bus.m_axis_tvalid, 1'b0);
    chk("p1_released_busy", released, 1'b0);
    release_n(2);
    chk("p1_released_cr1", released, 1'b0);
    release_n(1);
    chk("p1_released_idle", released, 1'b1);
    chk("p1_credits0", dut.credits, 0);

    // Round robin 0 then 2, twice (second round wraps rr_ptr from 3)
    reset = 1'b1; tick(); reset = 1'b0;
    round2(32'h10, 32'h20);
    chk("rr_credits_full", dut.credits, 4);
    release_n(4);
    round2(32'h30, 32'h40);
    release_n(4);
    chk("rr_credits0", dut.credits, 0);

    // Credit limit: 10-beat packet from src0, no releases
    k = 0; acc = 0;
    src(0, 1'b1, 32'h50, 1'b0);
    for (int c = 0; c < 12; c++) begin
      will = bus.s_axis_tready[0];
      tick();
      if (will) begin
        acc++; k++;
        src(0, 1'b1, 32'h50 + k, k == 9);
      end
    end
    chk("cr_accepted4", acc, 4);
    chk("cr_tready_low", bus.s_axis_tready[0], 1'b0);
    chk("cr_last_data", bus.m_axis_tdata, 32'h53);
    release_n(1);
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      will = bus.s_axis_tready[0];
      tick();
      if (will) begin
        acc++; k++;
        src(0, 1'b1, 32'h50 + k, k == 9);
      end
    end
    chk("cr_one_more", acc, 1);
    chk("cr_one_more_data", bus.m_axis_tdata, 32'h54);
    chk("cr_credits_full", dut.credits, 4);

    // Accept and release in the same cycle at credits=2
    src(0, 1'b0, 32'h55, 1'b0);
    release_n(2);
    chk("same_pre", dut.credits, 2);
    src(0, 1'b1, 32'h55, 1'b0);
    sigRelease = 1'b1;
    chk("same_tready", bus.s_axis_tready, 4'b0001);
    tick();
    sigRelease = 1'b0;
    src(0, 1'b0, 32'h56, 1'b0);
    chk("same_credits", dut.credits, 2);
    chk("same_data", bus.m_axis_tdata, 32'h55);
    release_n(1);
    chk("same_released_cr1", released, 1'b0);
    release_n(1);
    chk("same_released", released, 1'b1);
    chk("same_credits0", dut.credits, 0);

    // Backpressure: output stalls, no bubble on resume
    src(0, 1'b1, 32'h56, 1'b0);
    bus.m_axis_tready = 1'b0;
    tick();
    chk("bp_load_valid", bus.m_axis_tvalid, 1'b1);
    chk("bp_load_data", bus.m_axis_tdata, 32'h56);
    src(0, 1'b1, 32'h57, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_data", bus.m_axis_tdata, 32'h56);
      chk("bp_hold_tready", bus.s_axis_tready, 4'b0000);
    end
    bus.m_axis_tready = 1'b1;
    #1;
    chk("bp_resume_tready", bus.s_axis_tready, 4'b0001);
    tick();
    chk("bp_nobubble_valid", bus.m_axis_tvalid, 1'b1);
    chk("bp_nobubble_data", bus.m_axis_tdata, 32'h57);
    src(0, 1'b1, 32'h58, 1'b0);
    tick();
    chk("bp_b8_data", bus.m_axis_tdata, 32'h58);
    src(0, 1'b1, 32'h59, 1'b1);
    tick();
    chk("bp_b9_data", bus.m_axis_tdata, 32'h59);
    chk("bp_b9_last", bus.m_axis_tlast, 1'b1);
    chk("bp_credits", dut.credits, 4);
    src(0, 1'b0, 0, 1'b0);

    // Underflow is sticky
    release_n(4);
    chk("uf_clear", underflow, 1'b0);
    release_n(1);
    chk("uf_set", underflow, 1'b1);
    chk("uf_credits0", dut.credits, 0);
    tick();
    chk("uf_sticky", underflow, 1'b1);

    // Reset mid-packet from source 3 (rr_ptr is 1 here)
    src(3, 1'b1, 32'h70, 1'b0);
    tick();
    tick();
    chk("mr_data", bus.m_axis_tdata, 32'h70);
    chk("mr_tid", bus.m_axis_tid, 3);
    src(3, 1'b1, 32'h71, 1'b0);
    src(0, 1'b1, 32'h80, 1'b0);
    reset = 1'b1;
    #1;
    chk("mr_tready_in_reset", bus.s_axis_tready, 4'b0000);
    tick();
    chk("mr_valid", bus.m_axis_tvalid, 1'b0);
    chk("mr_data0", bus.m_axis_tdata, 0);
    chk("mr_tid0", bus.m_axis_tid, 0);
    chk("mr_last0", bus.m_axis_tlast, 1'b0);
    chk("mr_released", released, 1'b1);
    chk("mr_underflow", underflow, 1'b0);
    chk("mr_credits", dut.credits, 0);
    reset = 1'b0;
    tick();
    chk("mr_restart_src0", bus.s_axis_tready, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
